// File: rtl/issue_rat_prf_allocator_pkg.sv
// Shared issue-stage constants and types for the RAT PRF allocator.
package issue_rat_prf_allocator_pkg;

  localparam int unsigned PRF_WIDTH   = 6;
  localparam int unsigned NUM_PRF     = 64;
  localparam int unsigned INFLIGHT_W  = $clog2(NUM_PRF + 1);

  typedef logic [PRF_WIDTH-1:0]  prf_t;
  typedef logic [INFLIGHT_W-1:0] inflight_t;

endpackage : issue_rat_prf_allocator_pkg

// File: rtl/issue_rat_prf_queue.sv
// Register-based PRF FIFO; pointers carry an extra wrap bit for full/empty.
module issue_rat_prf_queue
  import issue_rat_prf_allocator_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic push_valid_i,
  input  prf_t push_data_i,
  output logic push_ready_o,
  output logic pop_valid_o,
  output prf_t pop_data_o,
  input  logic pop_ready_i
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  prf_t             mem_q [DEPTH];
  logic             full, empty, push_fire, pop_fire;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign push_fire = push_valid_i && !full;
  assign pop_fire  = pop_ready_i && !empty;

  assign push_ready_o = !full;
  assign pop_valid_o  = !empty;
  assign pop_data_o   = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // Pointer advance; wraps naturally modulo twice the depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Storage and pointer registers; reset discards all buffered entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_fire) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
    end
  end

endmodule : issue_rat_prf_queue

// File: rtl/issue_rat_prf_allocator.sv
// Rename-stage PRF allocator: prefetch from free list, grant to rename,
// route commit/flush releases back to the free list, track in-flight PRFs.
module issue_rat_prf_allocator
  import issue_rat_prf_allocator_pkg::*;
#(
  parameter int unsigned REDEEM_QUEUE_DEPTH_LOG2  = 2,
  parameter int unsigned ABANDON_QUEUE_DEPTH_LOG2 = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRF_WIDTH-1:0]  i_acquire_prf,
  input  logic                  i_acquire_valid,
  output logic                  o_acquire_ready,
  input  logic                  i_alloc_valid,
  output logic                  o_alloc_ready,
  output logic [PRF_WIDTH-1:0]  o_alloc_prf,
  input  logic [PRF_WIDTH-1:0]  i_commit_prf,
  input  logic                  i_commit_valid,
  output logic                  o_commit_ready,
  input  logic [PRF_WIDTH-1:0]  i_flush_prf,
  input  logic                  i_flush_valid,
  output logic                  o_flush_ready,
  output logic [PRF_WIDTH-1:0]  o_redeemed_prf,
  output logic                  o_redeemed_valid,
  input  logic                  i_redeemed_ready,
  output logic [PRF_WIDTH-1:0]  o_abandoned_prf,
  output logic                  o_abandoned_valid,
  input  logic                  i_abandoned_ready,
  output logic [INFLIGHT_W-1:0] o_inflight_count
);

  inflight_t inflight_q, inflight_d;
  logic      alloc_hs, commit_hs, flush_hs;

  // Two-entry prefetch buffer; grants come only from the registered head.
  issue_rat_prf_queue #(.DEPTH_LOG2(1)) u_prefetch (
    .clk          (clk),
    .reset        (reset),
    .push_valid_i (i_acquire_valid),
    .push_data_i  (i_acquire_prf),
    .push_ready_o (o_acquire_ready),
    .pop_valid_o  (o_alloc_ready),
    .pop_data_o   (o_alloc_prf),
    .pop_ready_i  (i_alloc_valid)
  );

  // Commit-released PRFs waiting for the free-list redeem port.
  issue_rat_prf_queue #(.DEPTH_LOG2(REDEEM_QUEUE_DEPTH_LOG2)) u_redeem (
    .clk          (clk),
    .reset        (reset),
    .push_valid_i (i_commit_valid),
    .push_data_i  (i_commit_prf),
    .push_ready_o (o_commit_ready),
    .pop_valid_o  (o_redeemed_valid),
    .pop_data_o   (o_redeemed_prf),
    .pop_ready_i  (i_redeemed_ready)
  );

  // Flush-released PRFs waiting for the free-list abandon port.
  issue_rat_prf_queue #(.DEPTH_LOG2(ABANDON_QUEUE_DEPTH_LOG2)) u_abandon (
    .clk          (clk),
    .reset        (reset),
    .push_valid_i (i_flush_valid),
    .push_data_i  (i_flush_prf),
    .push_ready_o (o_flush_ready),
    .pop_valid_o  (o_abandoned_valid),
    .pop_data_o   (o_abandoned_prf),
    .pop_ready_i  (i_abandoned_ready)
  );

  assign alloc_hs  = i_alloc_valid  && o_alloc_ready;
  assign commit_hs = i_commit_valid && o_commit_ready;
  assign flush_hs  = i_flush_valid  && o_flush_ready;

  // Net in-flight change, saturating at 0 and NUM_PRF on protocol errors.
  always_comb begin
    int next_v;
    next_v = int'(inflight_q) + int'(alloc_hs) - int'(commit_hs) - int'(flush_hs);
    inflight_d = inflight_q;
    if (next_v < 0)                 inflight_d = '0;
    else if (next_v > int'(NUM_PRF)) inflight_d = INFLIGHT_W'(NUM_PRF);
    else                            inflight_d = INFLIGHT_W'(next_v);
  end

  // In-flight counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight_q <= '0;
    else       inflight_q <= inflight_d;
  end

  assign o_inflight_count = inflight_q;

endmodule : issue_rat_prf_allocator

// File: doc/issue_rat_prf_allocator.md
ISSUE_RAT_PRF_ALLOCATOR -- requirements
Module: issue_rat_prf_allocator

Interface
REQ-001 SHALL have parameter REDEEM_QUEUE_DEPTH_LOG2, default 2, log2 depth of the commit-to-redeem queue.
REQ-002 SHALL have parameter ABANDON_QUEUE_DEPTH_LOG2, default 1, log2 depth of the flush-to-abandon queue.
REQ-003 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
REQ-004 SHALL have ports: i_acquire_prf  in  6  free PRF from free list; i_acquire_valid  in  1; o_acquire_ready  out  1.
REQ-005 SHALL have ports: i_alloc_valid  in  1  rename stage destination request; o_alloc_ready  out  1; o_alloc_prf  out  6  granted PRF.
REQ-006 SHALL have ports: i_commit_prf  in  6  old PRF released at commit; i_commit_valid  in  1; o_commit_ready  out  1.
REQ-007 SHALL have ports: i_flush_prf  in  6  speculative PRF released at flush; i_flush_valid  in  1; o_flush_ready  out  1.
REQ-008 SHALL have ports: o_redeemed_prf  out  6; o_redeemed_valid  out  1; i_redeemed_ready  in  1  (to free list redeem port).
REQ-009 SHALL have ports: o_abandoned_prf  out  6; o_abandoned_valid  out  1; i_abandoned_ready  in  1  (to free list abandon port).
REQ-010 SHALL have port o_inflight_count  out  7  PRFs granted and not yet returned.

Function
REQ-011 All handshakes SHALL complete in a cycle where valid & ready are both high; valid SHALL NOT depend combinationally on ready.
REQ-012 Prefetch buffer SHALL be a 2-entry FIFO filled from the acquire port; o_acquire_ready SHALL be registered-state only: high iff prefetch count < 2.
REQ-013 o_alloc_ready SHALL be high iff prefetch count != 0; o_alloc_prf SHALL be the prefetch head; no bypass from i_acquire_prf (acquire-to-grant latency exactly 1 cycle).
REQ-014 Simultaneous acquire push and alloc pop SHALL leave count unchanged and preserve FIFO order; at count 2 only pop occurs (count -> 1).
REQ-015 Commit handshakes SHALL push i_commit_prf into the redeem queue; o_commit_ready = redeem queue not full; o_redeemed_valid = not empty, o_redeemed_prf = head.
REQ-016 Flush handshakes SHALL push i_flush_prf into the abandon queue; o_flush_ready = abandon queue not full; o_abandoned_valid = not empty, o_abandoned_prf = head.
REQ-017 Queues SHALL allow push and pop in the same cycle when full (pop frees the slot only next cycle; ready stays low that cycle) and when empty (push visible next cycle).
REQ-018 Queue pointers SHALL wrap modulo depth; full/empty SHALL use an extra pointer bit.
REQ-019 o_inflight_count SHALL be +1 per alloc handshake, -1 per commit handshake, -1 per flush handshake, all in the same cycle, net applied (range 0..64, 7-bit).
REQ-020 Count underflow/overflow SHALL saturate at 0/64 (protocol error; no wrap).
REQ-021 Commit and flush paths SHALL be independent; both may handshake in one cycle.
REQ-022 Outputs not holding valid data SHALL drive PRF value 6'd0.

Reset
REQ-023 On reset assertion, asynchronously: prefetch and both queues empty, all pointers 0, o_inflight_count 0, all valid outputs 0, o_acquire_ready 1, o_commit_ready 1, o_flush_ready 1, o_alloc_ready 0.
REQ-024 Reset mid-operation SHALL discard all buffered PRFs without returning them (free list resets in the same cycle).
REQ-025 First handshake SHALL be possible on the first clk edge after reset deassertion.

Structure
REQ-026 PRF_WIDTH (6) and NUM_PRF (64) SHALL live in the shared issue package/header; no local redefinition.
REQ-027 One sub-module, issue_rat_prf_queue (parameterized depth-log2, 6-bit, register-based FIFO with async reset), SHALL implement prefetch, redeem and abandon storage (3 instances).

Verification
REQ-028 Reset, then acquire 5 then 9 back-to-back, alloc held high -> grants 5 (cycle 2), 9 (cycle 3); o_inflight_count 2.
REQ-029 Acquire 1,2,3 with alloc low -> o_acquire_ready falls after 2 pushes; 3 held on input; alloc once -> grant 1, then 3 accepted; order 2,3 preserved.
REQ-030 Commit 10,11,12,13,14 with i_redeemed_ready low -> first 4 accepted, o_commit_ready low; release ready -> redeemed 10..13 in order, then 14 accepted.
REQ-031 Same cycle: alloc handshake, commit 20, flush 21 -> inflight 3 -> 2; o_redeemed_prf 20 and o_abandoned_prf 21 valid next cycle.
REQ-032 Flush with inflight 0 -> count stays 0 (saturate); 65 allocs without returns -> count stays 64.
REQ-033 Assert reset with 2 prefetched, 3 queued -> all valids 0, counts 0 asynchronously, before next clk edge.
